cluster_txn_limiter: RTL
========================

// Module: cluster_txn_limiter
// PURPOSE
// - Per-cluster AXI transaction limiter and watchdog on a single cluster port of the cluster NoC demux.
// - Sits between the demux master port i and cluster i's slave port.
// - Gates only AW/AR/B/R valid-ready handshakes; payloads are wired around the block.
// - Counts outstanding writes (AW until B) and reads (AR until last R beat); stalls new requests at the limit.
// - Flags a stalled cluster (no response progress) and responses that arrive with nothing outstanding.
// PARAMETERS
// MaxWrTxns      8     max outstanding writes (>=1)
// MaxRdTxns      8     max outstanding reads (>=1)
// TimeoutCycles  1024  cycles without B/R progress, while outstanding>0, before timeout (>=2)
// BlockOnTimeout 1     1: hold AW/AR ready low while in TIMEOUT
// PORTS
// clk_i             in   1   clock
// rst_i             in   1   synchronous active-high reset
// slv_aw_valid_i    in   1   AW valid from demux
// slv_aw_ready_o    out  1   AW ready to demux
// mst_aw_valid_o    out  1   AW valid to cluster
// mst_aw_ready_i    in   1   AW ready from cluster
// slv_ar_valid_i    in   1   AR valid from demux
// slv_ar_ready_o    out  1   AR ready to demux
// mst_ar_valid_o    out  1   AR valid to cluster
// mst_ar_ready_i    in   1   AR ready from cluster
// mst_b_valid_i     in   1   B valid from cluster
// mst_b_ready_o     out  1   B ready to cluster
// slv_b_valid_o     out  1   B valid to demux
// slv_b_ready_i     in   1   B ready from demux
// mst_r_valid_i     in   1   R valid from cluster
// mst_r_last_i      in   1   R last from cluster
// mst_r_ready_o     out  1   R ready to cluster
// slv_r_valid_o     out  1   R valid to demux
// slv_r_ready_i     in   1   R ready from demux
// clear_i           in   1   clear timeout/protocol error flags
// wr_outstanding_o  out  $clog2(MaxWrTxns+1)  outstanding writes
// rd_outstanding_o  out  $clog2(MaxRdTxns+1)  outstanding reads
// timeout_o         out  1   sticky watchdog flag
// protocol_err_o    out  1   sticky: B or last-R handshake with zero outstanding
// BEHAVIOUR
// - Reset: counters 0, timer 0, FSM ACTIVE, timeout_o=0, protocol_err_o=0.
//   No registered handshake outputs; all valid/ready outputs are combinational.
// - Gating:
//   - aw_ok = (wr_cnt<MaxWrTxns) && !(BlockOnTimeout && state==TIMEOUT); ar_ok likewise for reads.
//   - mst_aw_valid_o = slv_aw_valid_i & aw_ok; slv_aw_ready_o = mst_aw_ready_i & aw_ok. Same for AR.
//   - B and R pass straight through: slv_b_valid_o=mst_b_valid_i, mst_b_ready_o=slv_b_ready_i; R same.
//   - Zero added latency; AXI valid-stability holds because aw_ok changes only on registered state.
// - Counting, registered:
//   - wr_cnt += AW handshake; wr_cnt -= B handshake. Both in the same cycle: wr_cnt unchanged.
//   - rd_cnt += AR handshake; rd_cnt -= R handshake with last=1. Non-last R beats do not decrement.
//   - A decrement at 0 is suppressed (no wrap); protocol_err_o is set instead.
//   - At limit, a same-cycle response does not open ready in that cycle; ready opens the next cycle.
// - Watchdog timer:
//   - Cleared when any B or R handshake occurs, or when wr_cnt+rd_cnt==0.
//   - Otherwise increments, saturating at TimeoutCycles.
// - FSM:
//   - ACTIVE -> TIMEOUT when timer==TimeoutCycles-1 and it would increment. timeout_o=1 from the next cycle.
//   - TIMEOUT -> ACTIVE on clear_i: clears timeout_o and the timer. Counts are kept.
//   - clear_i in ACTIVE clears protocol_err_o only.
//   - clear_i in the same cycle as a new error event: the event wins and the flag stays 1.
// - Reset mid-operation zeroes counts; in-flight responses arriving afterwards set protocol_err_o (expected).
// TESTING
// - AW valid held 10 cycles, MaxWrTxns=8, B never returned -> exactly 8 AW handshakes, wr_outstanding_o=8, slv_aw_ready_o=0.
// - wr_cnt=8, B handshake and pending AW in same cycle -> cnt 7, then AW accepted next cycle, cnt 8.
// - AR accepted, 4 R beats with last on beat 4 -> rd_outstanding_o 1,1,1,1 then 0 after the last beat.
// - TimeoutCycles=16, 1 write outstanding, no B -> timeout_o=1 exactly 16 cycles after the AW handshake.
//   AW then blocked; clear_i -> timeout_o=0 and AW accepted again.
// - B handshake with wr_cnt=0 -> protocol_err_o=1, wr_cnt stays 0; clear_i -> 0.
// - rst_i asserted with 3 writes/2 reads outstanding -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cluster_txn_limiter.sv
// Per-cluster AXI transaction limiter and watchdog.
// Gates AW/AR handshakes against outstanding-transaction limits, passes B/R
// straight through, tracks outstanding writes/reads and flags a cluster that
// stops making response progress or returns responses with nothing pending.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_ACTIVE  | normal operation, watchdog armed
// ST_TIMEOUT | watchdog expired; timeout_o high, requests optionally blocked
module cluster_txn_limiter #(
    parameter int unsigned MaxWrTxns      = 8,
    parameter int unsigned MaxRdTxns      = 8,
    parameter int unsigned TimeoutCycles  = 1024,
    parameter bit          BlockOnTimeout = 1'b1,
    localparam int unsigned WrW  = $clog2(MaxWrTxns + 1),
    localparam int unsigned RdW  = $clog2(MaxRdTxns + 1),
    localparam int unsigned TmrW = $clog2(TimeoutCycles + 1)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           slv_aw_valid_i,
    output logic           slv_aw_ready_o,
    output logic           mst_aw_valid_o,
    input  logic           mst_aw_ready_i,
    input  logic           slv_ar_valid_i,
    output logic           slv_ar_ready_o,
    output logic           mst_ar_valid_o,
    input  logic           mst_ar_ready_i,
    input  logic           mst_b_valid_i,
    output logic           mst_b_ready_o,
    output logic           slv_b_valid_o,
    input  logic           slv_b_ready_i,
    input  logic           mst_r_valid_i,
    input  logic           mst_r_last_i,
    output logic           mst_r_ready_o,
    output logic           slv_r_valid_o,
    input  logic           slv_r_ready_i,
    input  logic           clear_i,
    output logic [WrW-1:0] wr_outstanding_o,
    output logic [RdW-1:0] rd_outstanding_o,
    output logic           timeout_o,
    output logic           protocol_err_o
);

    typedef enum logic {
        ST_ACTIVE,
        ST_TIMEOUT
    } state_t;

    localparam logic [WrW-1:0]  WrMax   = WrW'(MaxWrTxns);
    localparam logic [RdW-1:0]  RdMax   = RdW'(MaxRdTxns);
    localparam logic [TmrW-1:0] TmrMax  = TmrW'(TimeoutCycles);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 1);

    state_t          state_q, state_d;
    logic [WrW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [RdW-1:0]  rd_cnt_q, rd_cnt_d;
    logic [TmrW-1:0] timer_q;
    logic            perr_q;

    logic aw_ok, ar_ok, blocked;
    logic aw_hs, ar_hs, b_hs, r_hs, r_last_hs;
    logic b_dec, r_dec, err_evt;
    logic timer_rst, timer_clr;

    // Request gating and handshake decode; only registered state feeds aw_ok/ar_ok
    always_comb begin
        blocked        = BlockOnTimeout && (state_q == ST_TIMEOUT);
        aw_ok          = (wr_cnt_q < WrMax) && !blocked;
        ar_ok          = (rd_cnt_q < RdMax) && !blocked;
        mst_aw_valid_o = slv_aw_valid_i & aw_ok;
        slv_aw_ready_o = mst_aw_ready_i & aw_ok;
        mst_ar_valid_o = slv_ar_valid_i & ar_ok;
        slv_ar_ready_o = mst_ar_ready_i & ar_ok;
        slv_b_valid_o  = mst_b_valid_i;
        mst_b_ready_o  = slv_b_ready_i;
        slv_r_valid_o  = mst_r_valid_i;
        mst_r_ready_o  = slv_r_ready_i;
        aw_hs          = slv_aw_valid_i & mst_aw_ready_i & aw_ok;
        ar_hs          = slv_ar_valid_i & mst_ar_ready_i & ar_ok;
        b_hs           = mst_b_valid_i & slv_b_ready_i;
        r_hs           = mst_r_valid_i & slv_r_ready_i;
        r_last_hs      = r_hs & mst_r_last_i;
        b_dec          = b_hs && (wr_cnt_q != '0);
        r_dec          = r_last_hs && (rd_cnt_q != '0);
        err_evt        = (b_hs && (wr_cnt_q == '0)) || (r_last_hs && (rd_cnt_q == '0));
        timer_rst      = b_hs || r_hs || ((wr_cnt_q == '0) && (rd_cnt_q == '0));
    end

    // Next outstanding counts; a decrement at zero is dropped and reported as an error
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        case ({aw_hs, b_dec})
            2'b10:   wr_cnt_d = wr_cnt_q + WrW'(1);
            2'b01:   wr_cnt_d = wr_cnt_q - WrW'(1);
            default: wr_cnt_d = wr_cnt_q;
        endcase
        case ({ar_hs, r_dec})
            2'b10:   rd_cnt_d = rd_cnt_q + RdW'(1);
            2'b01:   rd_cnt_d = rd_cnt_q - RdW'(1);
            default: rd_cnt_d = rd_cnt_q;
        endcase
    end

    // Watchdog FSM next state; expiry beats a same-cycle clear in ACTIVE
    always_comb begin
        state_d   = state_q;
        timer_clr = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (!timer_rst && (timer_q == TmrLast))
                    state_d = ST_TIMEOUT;
            end
            ST_TIMEOUT: begin
                if (clear_i) begin
                    state_d   = ST_ACTIVE;
                    timer_clr = 1'b1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // State, counters, watchdog timer and sticky error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_ACTIVE;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            timer_q  <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            if (timer_clr || timer_rst)
                timer_q <= '0;
            else if (timer_q != TmrMax)
                timer_q <= timer_q + TmrW'(1);
            if (err_evt)
                perr_q <= 1'b1;
            else if (clear_i)
                perr_q <= 1'b0;
        end
    end

    assign wr_outstanding_o = wr_cnt_q;
    assign rd_outstanding_o = rd_cnt_q;
    assign timeout_o        = (state_q == ST_TIMEOUT);
    assign protocol_err_o   = perr_q;

endmodule
